// File: rtl/adder_share_sched_if.sv
// Request/response bundle for the shared four-operand adder scheduler.
// master = requester/consumer side, slave = scheduler side.
interface adder_share_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_c;
  logic [NREQ*W-1:0] req_d;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W+1:0]      rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );
endinterface

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one (W+2)-bit adder among NREQ requesters;
// each accepted request is reduced as ((a+b)+c)+d over three cycles.
module adder_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst_n,
  adder_share_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    ADD3 = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   op_c;
  logic [W-1:0]   op_d;
  logic [W+1:0]   acc;
  logic           rsp_valid;
  logic           busy;

  logic [IDW-1:0] grant;
  logic           any_valid;
  logic [IDW:0]   cand;
  logic [W+1:0]   add_x;
  logic [W+1:0]   add_y;
  logic [W+1:0]   add_sum;

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand      = {1'b0, rr_ptr} + (IDW+1)'(k);
      cand      = (cand >= (IDW+1)'(NREQ)) ? cand - (IDW+1)'(NREQ) : cand;
      grant     = (!any_valid && bus.req_valid[cand[IDW-1:0]]) ? cand[IDW-1:0] : grant;
      any_valid = any_valid | bus.req_valid[cand[IDW-1:0]];
    end
  end

  // Accept strobe is combinational and suppressed while reset is asserted.
  assign bus.req_ready = (rst_n && (state == IDLE) && any_valid)
                       ? ({{(NREQ-1){1'b0}}, 1'b1} << grant)
                       : {NREQ{1'b0}};

  // Single shared adder; operands steered by the current chain step.
  always_comb begin
    case (state)
      ADD1: begin
        add_x = {2'b00, op_a};
        add_y = {2'b00, op_b};
      end
      ADD2: begin
        add_x = acc;
        add_y = {2'b00, op_c};
      end
      ADD3: begin
        add_x = acc;
        add_y = {2'b00, op_d};
      end
      default: begin
        add_x = '0;
        add_y = '0;
      end
    endcase
    add_sum = add_x + add_y;
  end

  // Scheduler FSM with registered response and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_d      <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a   <= bus.req_a[int'(grant)*W +: W];
            op_b   <= bus.req_b[int'(grant)*W +: W];
            op_c   <= bus.req_c[int'(grant)*W +: W];
            op_d   <= bus.req_d[int'(grant)*W +: W];
            id     <= grant;
            rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
            busy   <= 1'b1;
            state  <= ADD1;
          end else begin
            busy   <= 1'b0;
          end
        end
        ADD1: begin
          acc   <= add_sum;
          state <= ADD2;
        end
        ADD2: begin
          acc   <= add_sum;
          state <= ADD3;
        end
        ADD3: begin
          acc       <= add_sum;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // No accept here: a request must wait for the next IDLE cycle.
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_sum   = acc;
  assign bus.rsp_id    = id;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed self-checking bench for adder_share_sched (NREQ=4, W=8).
module tb_adder_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adder_share_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  adder_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_c[i*W +: W] = c;
    bus.req_d[i*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    #12;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 10'd0) begin errors++; $display("FAIL reset_rsp_sum: got %0d expected 0", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tick();
    bus.req_valid = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
    tick();
    bus.req_valid = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_c%0d: got %b expected 1", c, bus.busy); end
      checks++; if (bus.rsp_valid !== (c == 4)) begin errors++; $display("FAIL single_rsp_valid_c%0d: got %b expected %b", c, bus.rsp_valid, (c == 4)); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_c%0d: got %b expected 0000", c, bus.req_ready); end
      if (c < 4) tick();
    end
    checks++; if (bus.rsp_sum !== 10'd10) begin errors++; $display("FAIL single_sum: got %0d expected 10", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", bus.rsp_id); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", bus.busy); end
  endtask

  task automatic test_max();
    set_ops(2, 8'd255, 8'd255, 8'd255, 8'd255);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL max_grant: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick(); tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL max_rsp_valid: got %b expected 1", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 10'h3FC) begin errors++; $display("FAIL max_sum: got %0d expected 1020", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL max_id: got %0d expected 2", bus.rsp_id); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    logic [3:0] exp_ready;
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'(i), 8'(i), 8'(i));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_ready = 4'b0001 << exp_id[n];
      #1;
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", n, bus.req_ready, exp_ready); end
      tick(); tick(); tick(); tick();
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid_%0d: got %b expected 1", n, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== exp_id[n]) begin errors++; $display("FAIL rr_id_%0d: got %0d expected %0d", n, bus.rsp_id, exp_id[n]); end
      checks++; if (bus.rsp_sum !== 10'(4 * exp_id[n])) begin errors++; $display("FAIL rr_sum_%0d: got %0d expected %0d", n, bus.rsp_sum, 4 * exp_id[n]); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_resp_ready_%0d: got %b expected 0000", n, bus.req_ready); end
      tick();
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    set_ops(0, 8'd10, 8'd20, 8'd30, 8'd40);
    set_ops(1, 8'd5, 8'd6, 8'd7, 8'd8);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    tick(); tick(); tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b expected 1", c, bus.rsp_valid); end
      checks++; if (bus.rsp_sum !== 10'd100) begin errors++; $display("FAIL bp_sum_%0d: got %0d expected 100", c, bus.rsp_sum); end
      checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL bp_id_%0d: got %0d expected 0", c, bus.rsp_id); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0000", c, bus.req_ready); end
      tick();
    end
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b expected 0010", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_drop: got %b expected 0", bus.rsp_valid); end
    tick();
    bus.req_valid = 4'b0000;
    tick(); tick(); tick();
    checks++; if (bus.rsp_sum !== 10'd26) begin errors++; $display("FAIL bp_second_sum: got %0d expected 26", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL bp_second_id: got %0d expected 1", bus.rsp_id); end
    tick();
  endtask

  task automatic test_operand_change();
    set_ops(3, 8'd1, 8'd10, 8'd100, 8'd50);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL opchg_grant: got %b expected 1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    set_ops(3, 8'd200, 8'd200, 8'd200, 8'd200);
    tick(); tick(); tick();
    checks++; if (bus.rsp_sum !== 10'd161) begin errors++; $display("FAIL opchg_sum: got %0d expected 161", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL opchg_id: got %0d expected 3", bus.rsp_id); end
    tick();
  endtask

  task automatic test_reset_add2();
    set_ops(1, 8'd5, 8'd6, 8'd7, 8'd8);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst2_pre_grant: got %b expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    rst_n = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst2_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst2_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 10'd0) begin errors++; $display("FAIL rst2_sum: got %0d expected 0", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rst2_id: got %0d expected 0", bus.rsp_id); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst2_ready: got %b expected 0000", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst2_hold_valid: got %b expected 0", bus.rsp_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst2_post_grant: got %b expected 0010", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst2_post_busy: got %b expected 0", bus.busy); end
    tick();
    bus.req_valid = 4'b0000;
    tick(); tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rst2_rsp_valid_after: got %b expected 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL rst2_rsp_id_after: got %0d expected 1", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 10'd26) begin errors++; $display("FAIL rst2_rsp_sum_after: got %0d expected 26", bus.rsp_sum); end
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_d     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_add2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
